// File: rtl/stream_scale_offset_conv.sv
// Multi-channel stochastic-bitstream scale/offset converter: each channel adds a
// per-bit weight to a fractional residue and emits the carry as the output bit.
module stream_scale_offset_conv #(
  parameter int NUM_CH   = 8,
  parameter int ACC_W    = 4,
  parameter int RES_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [1:0]        mode,
  input  logic [ACC_W:0]    wgt1,
  input  logic [ACC_W:0]    wgt0,
  input  logic [NUM_CH-1:0] in,
  output logic [NUM_CH-1:0] out,
  output logic              out_valid
);

  localparam logic [ACC_W:0]   FULL = (ACC_W+1)'(1 << ACC_W);
  localparam logic [ACC_W:0]   HALF = (ACC_W+1)'(1 << (ACC_W - 1));
  localparam logic [ACC_W-1:0] RES0 = ACC_W'(RES_INIT);

  logic [ACC_W:0]    w_one;
  logic [ACC_W:0]    w_zero;
  logic [NUM_CH-1:0] carry;

  // Weight pair is shared by all channels; custom weights only reach the
  // datapath in mode 3, so undriven weights cannot leak into other modes.
  always_comb begin
    w_one  = FULL;
    w_zero = HALF;
    case (mode)
      2'd0: begin
        w_one  = FULL;
        w_zero = HALF;
      end
      2'd1: begin
        w_one  = HALF;
        w_zero = '0;
      end
      2'd2: begin
        w_one  = FULL;
        w_zero = '0;
      end
      default: begin
        w_one  = (wgt1 > FULL) ? FULL : wgt1;
        w_zero = (wgt0 > FULL) ? FULL : wgt0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ACC_W-1:0] res_reg;
      logic [ACC_W:0]   sum;

      // residue <= FULL-1 and weight <= FULL, so ACC_W+1 bits always suffice
      assign sum       = {1'b0, res_reg} + (in[gi] ? w_one : w_zero);
      assign carry[gi] = sum[ACC_W];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_reg <= RES0;
        end else if (clr) begin
          res_reg <= RES0;
        end else if (en) begin
          res_reg <= sum[ACC_W-1:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (clr || !en) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= carry;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_scale_offset_conv.sv
// Directed bench for stream_scale_offset_conv (NUM_CH=8, ACC_W=4, RES_INIT=0)
// plus a long-run ones-count check in every mode.
module tb_stream_scale_offset_conv;

  localparam int NUM_CH = 8;
  localparam int ACC_W  = 4;
  localparam int FULL   = 16;
  localparam logic [NUM_CH-1:0] ONES = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              clr;
  logic [1:0]        mode;
  logic [ACC_W:0]    wgt1;
  logic [ACC_W:0]    wgt0;
  logic [NUM_CH-1:0] din;
  logic [NUM_CH-1:0] dout;
  logic              vld;

  int checks = 0;
  int errors = 0;

  stream_scale_offset_conv #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .RES_INIT(0)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .wgt1(wgt1), .wgt0(wgt0), .in(din), .out(dout), .out_valid(vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s observed=%h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int wmodel(input int m, input bit b, input int w1, input int w0);
    int t;
    case (m)
      0: t = b ? FULL : FULL / 2;
      1: t = b ? FULL / 2 : 0;
      2: t = b ? FULL : 0;
      default: begin
        t = b ? w1 : w0;
        if (t > FULL) t = FULL;
      end
    endcase
    return t;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH-1:0] v;
    logic [15:0] lfsr [NUM_CH];
    int sumw [NUM_CH];
    int ones [NUM_CH];

    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'd0;
    wgt1 = '0; wgt0 = '0; din = '0;
    repeat (2) step();
    check("rst_out", dout, 0);
    check("rst_valid", vld, 0);
    rst = 1'b0;

    // mode 0, in=0: weight 8 each cycle -> 0,1,0,1; weights left undriven
    mode = 2'd0; en = 1'b1; din = '0; wgt1 = 'x; wgt0 = 'x;
    for (int i = 0; i < 4; i++) begin
      step();
      check("uni2bi_zero_out", dout, (i % 2) ? ONES : '0);
      check("uni2bi_zero_valid", vld, 1);
    end
    din = ONES;
    for (int i = 0; i < 2; i++) begin
      step();
      check("uni2bi_one_out", dout, ONES);
    end

    // mode 3, wgt1=12: residues 12,8,4,0 -> out 0,1,1,1
    mode = 2'd3; wgt1 = 5'd12; wgt0 = 5'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("custom_12_out", dout, (i % 4 == 0) ? '0 : ONES);
    end
    wgt1 = 5'd31;
    for (int i = 0; i < 3; i++) begin
      step();
      check("custom_sat_out", dout, ONES);
    end

    // mode 2: out is in delayed by one edge
    mode = 2'd2; wgt1 = 'x; wgt0 = 'x;
    for (int i = 0; i < 16; i++) begin
      v = NUM_CH'($urandom);
      din = v;
      step();
      check("bypass_out", dout, v);
    end

    // mode 1, in=1: weight 8 -> 0,1,0,1
    mode = 2'd1; din = ONES;
    for (int i = 0; i < 4; i++) begin
      step();
      check("half_out", dout, (i % 2) ? ONES : '0);
    end

    clr = 1'b1;
    step();
    check("clr_out", dout, 0);
    check("clr_valid", vld, 0);
    clr = 1'b0;

    // en toggling; disabled cycles present junk that must be ignored
    for (int i = 0; i < 4; i++) begin
      en = (i % 2 == 0);
      if (en) begin mode = 2'd0; din = '0; end
      else    begin mode = 2'd2; din = ONES; end
      step();
      check("gap_out", dout, (i == 2) ? ONES : '0);
      check("gap_valid", vld, (i % 2 == 0) ? 1 : 0);
    end

    // mid-stream clr: residue 8 is discarded, sequence restarts
    en = 1'b1; mode = 2'd0; din = '0;
    step();
    check("pre_clr_out", dout, 0);
    clr = 1'b1;
    step();
    check("mid_clr_out", dout, 0);
    check("mid_clr_valid", vld, 0);
    clr = 1'b0;
    step();
    check("post_clr_out0", dout, 0);
    step();
    check("post_clr_out1", dout, ONES);

    // leave residue at 8 with out=1, then pulse rst between edges
    step();
    mode = 2'd2; din = ONES;
    step();
    check("pre_rst_out", dout, ONES);
    #3 rst = 1'b1;
    #1;
    check("async_rst_out", dout, 0);
    check("async_rst_valid", vld, 0);
    #2 rst = 1'b0;
    mode = 2'd0; din = '0;
    step();
    check("post_rst_out0", dout, 0);
    check("post_rst_valid", vld, 1);
    step();
    check("post_rst_out1", dout, ONES);

    // long run in all modes: ones == floor(sum(w)/16) per channel
    for (int m = 0; m < 4; m++) begin
      clr = 1'b1;
      step();
      clr = 1'b0;
      mode = 2'(m);
      if (m == 3) begin wgt1 = 5'd20; wgt0 = 5'd3; end
      else        begin wgt1 = 'x;    wgt0 = 'x;   end
      for (int c = 0; c < NUM_CH; c++) begin
        lfsr[c] = 16'hACE1 ^ 16'(c * 16'h1357 + m * 16'h0F0F + 1);
        sumw[c] = 0;
        ones[c] = 0;
      end
      for (int n = 0; n < 4096; n++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          lfsr[c] = lfsr[c][0] ? ((lfsr[c] >> 1) ^ 16'hB400) : (lfsr[c] >> 1);
          case (c % 3)
            0: v[c] = lfsr[c][0];
            1: v[c] = lfsr[c][0] & lfsr[c][1];
            default: v[c] = lfsr[c][0] | lfsr[c][1];
          endcase
          sumw[c] += wmodel(m, v[c], 20, 3);
        end
        din = v;
        step();
        for (int c = 0; c < NUM_CH; c++) ones[c] += int'(dout[c]);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        check($sformatf("long_m%0d_ch%0d", m, c), 64'(ones[c]), 64'(sumw[c] / FULL));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_scale_offset_conv.md
Name: stream_scale_offset_conv

Overview:
- Multi-channel, parametrised stochastic-bitstream converter. Generalises the single-channel unipolar-to-bipolar converter that produces out rate = (p+1)/2.
- Each channel accumulates a per-bit weight into a fractional residue and emits the carry bit. The result is an output stream of rate p·W1 + (1−p)·W0 for input rate p, with weights in units of 2^-ACC_W.
- Sits in the stream datapath between stochastic generators and bipolar/scaled arithmetic, and also serves as a latency-matching bypass.

Parameters:
- NUM_CH, 8, number of independent bitstream channels (≥1).
- ACC_W, 4, fractional residue width in bits (≥1). Weights are in units of 2^-ACC_W.
- RES_INIT, 0, residue value loaded on reset and on clr (< 2^ACC_W).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  channel advance enable, common to all channels.
- clr  input  1  synchronous clear of residues and outputs.
- mode  input  2  conversion mode, common to all channels.
- wgt1  input  ACC_W+1  weight applied when an input bit is 1 (mode 3 only).
- wgt0  input  ACC_W+1  weight applied when an input bit is 0 (mode 3 only).
- in  input  NUM_CH  input bit per channel.
- out  output  NUM_CH  converted bit per channel, registered.
- out_valid  output  1  high when out carries a converted bit.

Behaviour:
- Reset (rst=1, async):
  - every residue := RES_INIT; out := 0; out_valid := 0.
  - Applies immediately, including mid-stream. The first edge after rst deasserts behaves as a normal cycle.
- Weight selection per channel (FULL = 2^ACC_W, HALF = 2^(ACC_W−1)):
  - mode 0 (uni2bi): w = in ? FULL : HALF → rate (p+1)/2.
  - mode 1 (half): w = in ? HALF : 0 → rate p/2.
  - mode 2 (bypass): w = in ? FULL : 0 → out = in delayed 1 cycle.
  - mode 3 (custom): w = in ? wgt1 : wgt0. Any weight > FULL saturates to FULL.
- Datapath per channel on each rising edge with en=1, clr=0:
  - sum = residue + w, width ACC_W+1. Cannot overflow, since max is (FULL−1)+FULL.
  - out[i] := sum[ACC_W]; residue := sum[ACC_W−1:0].
  - out_valid := 1.
- Latency: exactly 1 cycle from in sampled to out. Throughput: 1 bit per channel per enabled cycle.
- en=0, clr=0:
  - residues hold; out := 0; out_valid := 0.
  - in, mode and weights are ignored that cycle.
- clr=1: priority over en.
  - all residues := RES_INIT; out := 0; out_valid := 0.
  - Input bits presented that cycle are discarded.
- Mode or weight change:
  - takes effect on the next enabled edge; the residue is not cleared.
  - Mode and weights are sampled only on enabled edges and are shared by all channels in that cycle.
- Channels are fully independent: no cross-channel state.
- Long-run accuracy: over N enabled cycles, ones(out) = floor((RES_INIT + Σw)/FULL), i.e. count error < 1 bit.
- No X propagation from wgt0/wgt1 when mode≠3. Weights must not affect state in modes 0–2.

Test Plan:
- ACC_W=1, RES_INIT=0, mode 0, en=1, in=all-zeros → out per channel 0,1,0,1,… starting the cycle after the first enable; in=all-ones → out all ones; out_valid=1 from the first edge.
- ACC_W=2, mode 3, wgt1=3, in=1 constant → out 0,1,1,1 repeating (residues 3,2,1,0). Then wgt1=7 → saturates to 4 → out constant 1.
- ACC_W=4, mode 2, random in on 8 channels → out equals in delayed 1 cycle bit-exact; mode 1 with in=1 constant → out alternates 0,1 (rate 1/2).
- en toggling 1,0,1,0 with mode 0 and in=0 → out 0,0,1,0; out_valid 1,0,1,0; residue preserved across gaps, so the carry appears on the second enabled cycle.
- Mid-stream clr with en=1 → next edge out=0, out_valid=0, residue=RES_INIT; sequence restarts identically to post-reset. rst asserted between edges → out and out_valid drop to 0 immediately, without waiting for an edge.
- Long run: 4096 enabled cycles, LFSR input of known rate on each channel, all four modes → output ones count equals floor((RES_INIT+Σw)/2^ACC_W) exactly per channel.
